hdmi_tmds_frontend: RTL and testbench

Single-clock, pipelined TMDS encode front-end for three channels: blue=ch0, green=ch1, red=ch2. It also inserts the HDMI video preamble and leading guard band before each active-video run. Outputs are 10-bit symbols in the pixel-clock domain, ready for the existing per-channel serialisers. Successor to the fixed DVI-style encoder wrapper: preamble and guard lengths are parametrised, DVI/HDMI mode is selectable at run time, and phase status is exported.

---
 rtl/hdmi_tmds_if.sv | 25 ++
 rtl/hdmi_tmds_frontend.sv | 206 ++++++++++++++++++++
 tb/tb_hdmi_tmds_frontend.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_tmds_if.sv
// Pixel/sync inputs and encoded TMDS symbol outputs of hdmi_tmds_frontend.
interface hdmi_tmds_if;
  logic [7:0] din_r;
  logic [7:0] din_g;
  logic [7:0] din_b;
  logic       de;
  logic       hsync;
  logic       vsync;
  logic       hdmi_mode;
  logic [9:0] dout_r;
  logic [9:0] dout_g;
  logic [9:0] dout_b;
  logic       dout_de;
  logic [1:0] dout_phase;

  modport master (
    output din_r, din_g, din_b, de, hsync, vsync, hdmi_mode,
    input  dout_r, dout_g, dout_b, dout_de, dout_phase
  );

  modport slave (
    input  din_r, din_g, din_b, de, hsync, vsync, hdmi_mode,
    output dout_r, dout_g, dout_b, dout_de, dout_phase
  );
endinterface

// File: rtl/hdmi_tmds_frontend.sv
// Three-channel TMDS encoder (ch0=blue, ch1=green, ch2=red) with HDMI preamble/guard insertion.
// Define HDMI_GUARD_EN for the lookahead delay line; without it this is a 2-cycle pure DVI encoder.
module hdmi_tmds_frontend #(
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2
) (
  input logic        clk1x,
  input logic        rst,
  hdmi_tmds_if.slave bus
);

  typedef enum logic [1:0] {
    PH_CTRL  = 2'd0,
    PH_PRE   = 2'd1,
    PH_GUARD = 2'd2,
    PH_VIDEO = 2'd3
  } phase_e;

  localparam logic [9:0] TOK_00  = 10'b1101010100;
  localparam logic [9:0] TOK_01  = 10'b0010101011;
  localparam logic [9:0] TOK_10  = 10'b0101010100;
  localparam logic [9:0] TOK_11  = 10'b1010101011;
  localparam logic [9:0] GB_CH02 = 10'b1011001100;
  localparam logic [9:0] GB_CH1  = 10'b0100110011;

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [8:0] min_trans(input logic [7:0] d);
    logic [8:0] q;
    logic [3:0] n1;
    logic       use_xnor;
    n1       = ones8(d);
    use_xnor = (n1 > 4'd4) || (n1 == 4'd4 && !d[0]);
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~use_xnor;
    return q;
  endfunction

  function automatic logic [9:0] ctl_token(input logic c1, input logic c0);
    case ({c1, c0})
      2'b00:   return TOK_00;
      2'b01:   return TOK_01;
      2'b10:   return TOK_10;
      default: return TOK_11;
    endcase
  endfunction

  // Returns {next running disparity, balanced symbol}.
  function automatic logic [14:0] dc_balance(input logic [8:0] qm, input logic [4:0] cnt);
    logic signed [5:0] disp;
    logic signed [5:0] cnt_x;
    logic signed [5:0] cnt_n;
    logic        [9:0] sym;
    disp  = $signed({1'b0, ones8(qm[7:0]), 1'b0}) - 6'sd8;
    cnt_x = $signed({cnt[4], cnt});
    if (cnt == 5'd0 || disp == 6'sd0) begin
      sym   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt_n = qm[8] ? (cnt_x + disp) : (cnt_x - disp);
    end else if ((!cnt[4] && disp > 6'sd0) || (cnt[4] && disp < 6'sd0)) begin
      sym   = {1'b1, qm[8], ~qm[7:0]};
      cnt_n = cnt_x + (qm[8] ? 6'sd2 : 6'sd0) - disp;
    end else begin
      sym   = {1'b0, qm[8], qm[7:0]};
      cnt_n = cnt_x - (qm[8] ? 6'sd0 : 6'sd2) + disp;
    end
    return {cnt_n[4:0], sym};
  endfunction

  logic [7:0] enc_pix [3];
  logic       enc_hs;
  logic       enc_vs;
  phase_e     enc_phase;

`ifdef HDMI_GUARD_EN
  localparam int LEAD = PREAMBLE_LEN + GUARD_LEN;

  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic       mode;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } sample_t;

  sample_t       dl_q [LEAD];
  sample_t       live_s;
  sample_t       old_s;
  logic [LEAD:1] de_ahead;

  assign live_s = {bus.de, bus.hsync, bus.vsync, bus.hdmi_mode, bus.din_r, bus.din_g, bus.din_b};
  assign old_s  = dl_q[LEAD-1];

  always_ff @(posedge clk1x or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LEAD; i++) dl_q[i] <= '0;
    end else begin
      dl_q[0] <= live_s;
      for (int i = 1; i < LEAD; i++) dl_q[i] <= dl_q[i-1];
    end
  end

  // de_ahead[k]: de of the sample k cycles newer than the one leaving the line; k=LEAD is live.
  for (genvar gi = 1; gi < LEAD; gi++) begin : g_ahead
    assign de_ahead[gi] = dl_q[LEAD-1-gi].de;
  end
  assign de_ahead[LEAD] = bus.de;

  always_comb begin
    enc_pix[0] = old_s.b;
    enc_pix[1] = old_s.g;
    enc_pix[2] = old_s.r;
    enc_hs     = old_s.hs;
    enc_vs     = old_s.vs;
    enc_phase  = PH_CTRL;
    if (old_s.de)                    enc_phase = PH_VIDEO;
    else if (!old_s.mode)            enc_phase = PH_CTRL;
    else if (|de_ahead[GUARD_LEN:1]) enc_phase = PH_GUARD;
    else if (|de_ahead)              enc_phase = PH_PRE;
  end
`else
  logic unused_mode;
  assign unused_mode = bus.hdmi_mode;

  always_comb begin
    enc_pix[0] = bus.din_b;
    enc_pix[1] = bus.din_g;
    enc_pix[2] = bus.din_r;
    enc_hs     = bus.hsync;
    enc_vs     = bus.vsync;
    enc_phase  = bus.de ? PH_VIDEO : PH_CTRL;
  end
`endif

  logic [8:0] qm_q [3];
  phase_e     ph_a_q;
  logic       hs_a_q;
  logic       vs_a_q;

  always_ff @(posedge clk1x or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < 3; c++) qm_q[c] <= '0;
      ph_a_q <= PH_CTRL;
      hs_a_q <= 1'b0;
      vs_a_q <= 1'b0;
    end else begin
      for (int c = 0; c < 3; c++) qm_q[c] <= min_trans(enc_pix[c]);
      ph_a_q <= enc_phase;
      hs_a_q <= enc_hs;
      vs_a_q <= enc_vs;
    end
  end

  logic [4:0] cnt_q   [3];
  logic [4:0] cnt_d   [3];
  logic [9:0] sym_q   [3];
  logic [9:0] sym_d   [3];
  logic [9:0] ctl_sym [3];
  phase_e     ph_b_q;

  always_comb begin
    ctl_sym[0] = ctl_token(vs_a_q, hs_a_q);
    ctl_sym[1] = (ph_a_q == PH_PRE) ? TOK_01 : TOK_00;
    ctl_sym[2] = TOK_00;
    if (ph_a_q == PH_GUARD) begin
      ctl_sym[0] = GB_CH02;
      ctl_sym[1] = GB_CH1;
      ctl_sym[2] = GB_CH02;
    end
    for (int c = 0; c < 3; c++) begin
      cnt_d[c] = '0;
      sym_d[c] = ctl_sym[c];
      if (ph_a_q == PH_VIDEO) {cnt_d[c], sym_d[c]} = dc_balance(qm_q[c], cnt_q[c]);
    end
  end

  always_ff @(posedge clk1x or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < 3; c++) begin
        cnt_q[c] <= '0;
        sym_q[c] <= TOK_00;
      end
      ph_b_q <= PH_CTRL;
    end else begin
      for (int c = 0; c < 3; c++) begin
        cnt_q[c] <= cnt_d[c];
        sym_q[c] <= sym_d[c];
      end
      ph_b_q <= ph_a_q;
    end
  end

  assign bus.dout_b     = sym_q[0];
  assign bus.dout_g     = sym_q[1];
  assign bus.dout_r     = sym_q[2];
  assign bus.dout_phase = ph_b_q;
  assign bus.dout_de    = (ph_b_q == PH_VIDEO);

endmodule

// File: tb/tb_hdmi_tmds_frontend.sv
// Randomized directed-step bench for hdmi_tmds_frontend against a cycle-indexed reference model.
module tb_hdmi_tmds_frontend;
  localparam int PRE = 8;
  localparam int GRD = 2;
`ifdef HDMI_GUARD_EN
  localparam int LEAD = PRE + GRD;
  localparam int LAT  = LEAD + 2;
`else
  localparam int LAT  = 2;
`endif
  localparam int HN = 8192;

  logic clk1x = 1'b0;
  logic rst   = 1'b1;
  hdmi_tmds_if bus ();

  hdmi_tmds_frontend #(.PREAMBLE_LEN(PRE), .GUARD_LEN(GRD)) dut (
    .clk1x(clk1x),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clk1x = ~clk1x;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_s      = -1;
  int mcnt [3];

  logic       h_de [HN];
  logic       h_hs [HN];
  logic       h_vs [HN];
  logic       h_mode [HN];
  logic [7:0] h_r [HN];
  logic [7:0] h_g [HN];
  logic [7:0] h_b [HN];
  logic [9:0] o_r [HN];
  logic [9:0] o_g [HN];
  logic [9:0] o_b [HN];
  logic       o_de [HN];
  logic [1:0] o_ph [HN];
  logic [9:0] tok [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  function automatic logic hde(int s);   return (s >= 0) ? h_de[s]   : 1'b0; endfunction
  function automatic logic hhs(int s);   return (s >= 0) ? h_hs[s]   : 1'b0; endfunction
  function automatic logic hvs(int s);   return (s >= 0) ? h_vs[s]   : 1'b0; endfunction
  function automatic logic hmode(int s); return (s >= 0) ? h_mode[s] : 1'b0; endfunction

  // Phase of input sample s: video if de, else guard/preamble by distance to the next de.
  function automatic int model_phase(int s);
    int ph;
    int near;
    ph   = 0;
    near = 0;
    if (hde(s)) ph = 3;
`ifdef HDMI_GUARD_EN
    else if (hmode(s)) begin
      for (int k = LEAD; k >= 1; k--) if (hde(s + k)) near = k;
      if (near >= 1 && near <= GRD) ph = 2;
      else if (near > GRD)          ph = 1;
    end
`endif
    return ph;
  endfunction

  task automatic enc_video(input int ch, input logic [7:0] d, output logic [9:0] sym);
    int n1d, n1, n0, q8;
    logic xn;
    logic q8b;
    logic [7:0] qm, m;
    n1d = $countones(d);
    xn  = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    // Bit i is the parity of d[i:0], inverted on odd bits in the XNOR variant.
    for (int i = 0; i < 8; i++) begin
      m     = 8'((1 << (i + 1)) - 1);
      qm[i] = (($countones(d & m) % 2) == 1) ^ (xn && (i % 2 == 1));
    end
    q8  = xn ? 0 : 1;
    q8b = (q8 == 1);
    n1  = $countones(qm);
    n0  = 8 - n1;
    if (mcnt[ch] == 0 || n1 == n0) begin
      sym = {~q8b, q8b, q8b ? qm : ~qm};
      mcnt[ch] += q8b ? (n1 - n0) : (n0 - n1);
    end else if ((mcnt[ch] > 0 && n1 > n0) || (mcnt[ch] < 0 && n0 > n1)) begin
      sym = {1'b1, q8b, ~qm};
      mcnt[ch] += 2 * q8 + (n0 - n1);
    end else begin
      sym = {1'b0, q8b, qm};
      mcnt[ch] += -2 * (1 - q8) + (n1 - n0);
    end
  endtask

  task automatic model_out(input int s, output logic [9:0] er, output logic [9:0] eg,
                           output logic [9:0] eb, output logic ede, output logic [1:0] eph);
    int ph;
    logic [1:0] c;
    ph  = model_phase(s);
    eph = 2'(ph);
    ede = (ph == 3);
    if (ph == 3) begin
      enc_video(0, h_b[s], eb);
      enc_video(1, h_g[s], eg);
      enc_video(2, h_r[s], er);
    end else begin
      mcnt = '{0, 0, 0};
      c  = {hvs(s), hhs(s)};
      eb = tok[c];
      eg = (ph == 1) ? tok[1] : tok[0];
      er = tok[0];
      if (ph == 2) begin
        eb = 10'h2CC;
        eg = 10'h133;
        er = 10'h2CC;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    logic [9:0] er, eg, eb;
    logic       ede;
    logic [1:0] eph;
    int s;
    @(posedge clk1x);
    #1;
    s = cyc - (LAT - 1);
    model_out(s, er, eg, eb, ede, eph);
    if (s >= 0) begin
      o_r[s]  = bus.dout_r;
      o_g[s]  = bus.dout_g;
      o_b[s]  = bus.dout_b;
      o_de[s] = bus.dout_de;
      o_ph[s] = bus.dout_phase;
    end
    chk("dout_r", bus.dout_r, er);
    chk("dout_g", bus.dout_g, eg);
    chk("dout_b", bus.dout_b, eb);
    chk("dout_de", {9'b0, bus.dout_de}, {9'b0, ede});
    chk("dout_phase", {8'b0, bus.dout_phase}, {8'b0, eph});
    last_s = s;
    cyc++;
  endtask

  task automatic apply(input logic de, input logic hs, input logic vs, input logic mode,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    bus.de = de; bus.hsync = hs; bus.vsync = vs; bus.hdmi_mode = mode;
    bus.din_r = r; bus.din_g = g; bus.din_b = b;
    h_de[cyc] = de; h_hs[cyc] = hs; h_vs[cyc] = vs; h_mode[cyc] = mode;
    h_r[cyc] = r; h_g[cyc] = g; h_b[cyc] = b;
    tick();
  endtask

  function automatic logic [7:0] rpix();
    int sel;
    sel = $urandom_range(0, 5);
    if (sel == 0) return 8'h00;
    if (sel == 1) return 8'hFF;
    return 8'($urandom);
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_r"}, bus.dout_r, 10'h354);
    chk({tag, "_g"}, bus.dout_g, 10'h354);
    chk({tag, "_b"}, bus.dout_b, 10'h354);
    chk({tag, "_de"}, {9'b0, bus.dout_de}, 10'h000);
    chk({tag, "_ph"}, {8'b0, bus.dout_phase}, 10'h000);
  endtask

  initial begin
    int mark, t0, g0, gap, vlen;
    logic mode;
    mcnt = '{0, 0, 0};
    bus.de = 1'b0; bus.hsync = 1'b0; bus.vsync = 1'b0; bus.hdmi_mode = 1'b0;
    bus.din_r = 8'h00; bus.din_g = 8'h00; bus.din_b = 8'h00;

    #2 rst = 1'b0;
    #1 check_reset_outputs("por");
    $display("step por_reset: outputs checked while rst low");
    repeat (2) @(posedge clk1x);
    #3 rst = 1'b1;

    for (int i = 0; i < 16; i++) apply(1'b0, 1'b0, 1'b1, 1'b0, rpix(), rpix(), rpix());
    chk("dvi_b", o_b[last_s], 10'h154);
    chk("dvi_g", o_g[last_s], 10'h354);
    chk("dvi_r", o_r[last_s], 10'h354);
    chk("dvi_ph", {8'b0, o_ph[last_s]}, 10'h000);
    $display("step dvi_blank: vsync=1 hsync=0 hdmi_mode=0");

    for (int i = 0; i < 8; i++) apply(1'b0, 1'b0, 1'b0, 1'b0, rpix(), rpix(), rpix());
    mark = cyc;
    for (int i = 0; i < 2; i++) apply(1'b1, 1'b0, 1'b0, 1'b0, rpix(), rpix(), 8'h00);
    for (int i = 0; i < LAT + 2; i++) apply(1'b0, 1'b0, 1'b0, 1'b0, rpix(), rpix(), rpix());
    chk("dcbal_first", o_b[mark], 10'h100);
    chk("dcbal_second", o_b[mark + 1], 10'h3FF);
    $display("step dc_balance: two zero blue pixels from cnt=0");

    for (int i = 0; i < 20; i++)
      apply(1'b0, 1'($urandom), 1'($urandom), 1'b1, rpix(), rpix(), rpix());
    t0 = cyc;
    for (int i = 0; i < 16; i++) apply(1'b1, 1'b0, 1'b0, 1'b1, rpix(), rpix(), rpix());
`ifdef HDMI_GUARD_EN
    for (int k = 3; k <= 10; k++) begin
      chk("pre_phase", {8'b0, o_ph[t0 - k]}, 10'h001);
      chk("pre_g", o_g[t0 - k], 10'h0AB);
    end
    for (int k = 1; k <= 2; k++) begin
      chk("guard_phase", {8'b0, o_ph[t0 - k]}, 10'h002);
      chk("guard_g", o_g[t0 - k], 10'h133);
      chk("guard_b", o_b[t0 - k], 10'h2CC);
    end
`else
    chk("blank_phase", {8'b0, o_ph[t0 - 1]}, 10'h000);
    chk("blank_g", o_g[t0 - 1], 10'h354);
`endif
    chk("video_phase", {8'b0, o_ph[t0]}, 10'h003);
    $display("step hdmi_insert: 20 blank then video, hdmi_mode=1");

    g0 = cyc;
    for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 1'b0, 1'b1, rpix(), rpix(), rpix());
    for (int i = 0; i < 14; i++) apply(1'b1, 1'b0, 1'b0, 1'b1, rpix(), rpix(), rpix());
`ifdef HDMI_GUARD_EN
    chk("gap_pre", {8'b0, o_ph[g0]}, 10'h001);
    chk("gap_guard0", {8'b0, o_ph[g0 + 1]}, 10'h002);
    chk("gap_guard1", {8'b0, o_ph[g0 + 2]}, 10'h002);
`else
    chk("gap_ctrl", {8'b0, o_ph[g0]}, 10'h000);
`endif
    chk("gap_last_video", {8'b0, o_ph[g0 - 1]}, 10'h003);
    chk("gap_next_video", {8'b0, o_ph[g0 + 3]}, 10'h003);
    chk("gap_next_de", {9'b0, o_de[g0 + 3]}, 10'h001);
    $display("step short_gap: 3 blank cycles between video runs");

    for (int run = 0; run < 40; run++) begin
      mode = 1'($urandom_range(0, 1));
      gap  = $urandom_range(1, 24);
      vlen = $urandom_range(1, 20);
      for (int i = 0; i < gap; i++) begin
        if ($urandom_range(0, 9) == 0) mode = ~mode;
        apply(1'b0, 1'($urandom), 1'($urandom), mode, rpix(), rpix(), rpix());
      end
      for (int i = 0; i < vlen; i++) apply(1'b1, 1'($urandom), 1'($urandom), mode, rpix(), rpix(), rpix());
    end
    $display("step random_frames: 40 random blank/video runs");

    for (int i = 0; i < 5; i++) apply(1'b1, 1'b0, 1'b0, 1'b1, rpix(), rpix(), rpix());
    #1 rst = 1'b0;
    #1 check_reset_outputs("midrst");
    #1 rst = 1'b1;
    cyc    = 0;
    last_s = -1;
    mcnt   = '{0, 0, 0};
    for (int i = 0; i < 20; i++) apply(1'b1, 1'b0, 1'b0, 1'b1, rpix(), rpix(), rpix());
    for (int i = 0; i < 16; i++) apply(1'b0, 1'b1, 1'b0, 1'b1, rpix(), rpix(), rpix());
    $display("step midframe_reset: reset during de=1, then resumed video");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
